// File: rtl/eight_point_ifft_serial.sv
// rtl/eight_point_ifft_serial.sv - streaming 8-point inverse FFT, one shared radix-2 butterfly
module eight_point_ifft_serial #(
    parameter int SCALE = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_real,
    input  logic [15:0] in_imag,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_real,
    output logic [15:0] out_imag,
    output logic [2:0]  out_index,
    output logic        out_last,
    output logic        busy
);
    localparam logic [1:0] ST_LOAD    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_UNLOAD  = 2'd2;

    logic [1:0]        r_state;
    logic [2:0]        r_cnt;
    logic [1:0]        r_stage;
    logic [1:0]        r_bfly;
    logic signed [15:0] r_re [0:7];
    logic signed [15:0] r_im [0:7];

    logic [2:0]         w_p;
    logic [2:0]         w_q;
    logic [1:0]         w_k;
    logic [2:0]         w_wr_idx;
    logic signed [15:0] w_a;
    logic signed [15:0] w_b;
    logic signed [16:0] w_diff;
    logic signed [16:0] w_sum;
    logic signed [16:0] w_nsum;
    logic signed [15:0] w_t_re;
    logic signed [15:0] w_t_im;
    logic signed [15:0] w_xp_re;
    logic signed [15:0] w_xp_im;

    function automatic logic signed [15:0] sm_to_tc(input logic [15:0] x);
        logic signed [15:0] m;
        m = signed'({1'b0, x[14:0]});
        return x[15] ? -m : m;
    endfunction

    function automatic logic [15:0] tc_to_sm(input logic signed [15:0] v);
        if (v == -16'sd32768)
            return 16'hFFFF;
        if (v[15])
            return {1'b1, 15'(-v)};
        return v;
    endfunction

    // multiply by cos(pi/4) in Q15, floor-truncated
    function automatic logic signed [15:0] mul_c(input logic signed [16:0] v);
        return 16'((33'(v) * 33'sd23170) >>> 15);
    endfunction

    always_comb begin
        w_p = 3'd0;
        w_q = 3'd0;
        w_k = 2'd0;
        case (r_stage)
            2'd0: begin
                w_p = {r_bfly, 1'b0};
                w_q = {r_bfly, 1'b1};
                w_k = 2'd0;
            end
            2'd1: begin
                w_p = {r_bfly[1], 1'b0, r_bfly[0]};
                w_q = {r_bfly[1], 1'b1, r_bfly[0]};
                w_k = {r_bfly[0], 1'b0};
            end
            default: begin
                w_p = {1'b0, r_bfly};
                w_q = {1'b1, r_bfly};
                w_k = r_bfly;
            end
        endcase
    end

    assign w_a     = r_re[w_q];
    assign w_b     = r_im[w_q];
    assign w_xp_re = r_re[w_p];
    assign w_xp_im = r_im[w_p];
    assign w_diff  = 17'(w_a) - 17'(w_b);
    assign w_sum   = 17'(w_a) + 17'(w_b);
    assign w_nsum  = -(17'(w_a)) - 17'(w_b);

    always_comb begin
        w_t_re = w_a;
        w_t_im = w_b;
        case (w_k)
            2'd1: begin
                w_t_re = mul_c(w_diff);
                w_t_im = mul_c(w_sum);
            end
            2'd2: begin
                w_t_re = -w_b;
                w_t_im = w_a;
            end
            2'd3: begin
                w_t_re = mul_c(w_nsum);
                w_t_im = mul_c(w_diff);
            end
            default: begin
                w_t_re = w_a;
                w_t_im = w_b;
            end
        endcase
    end

    // load counter doubles as output index; bit-reverse it for the input buffer slot
    assign w_wr_idx = {r_cnt[0], r_cnt[1], r_cnt[2]};

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= ST_LOAD;
            r_cnt   <= 3'd0;
            r_stage <= 2'd0;
            r_bfly  <= 2'd0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (in_valid) begin
                        r_cnt <= r_cnt + 3'd1;
                        if (r_cnt == 3'd7)
                            r_state <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    r_bfly <= r_bfly + 2'd1;
                    if (r_bfly == 2'd3) begin
                        if (r_stage == 2'd2) begin
                            r_stage <= 2'd0;
                            r_state <= ST_UNLOAD;
                        end else begin
                            r_stage <= r_stage + 2'd1;
                        end
                    end
                end
                ST_UNLOAD: begin
                    if (out_ready) begin
                        r_cnt <= r_cnt + 3'd1;
                        if (r_cnt == 3'd7)
                            r_state <= ST_LOAD;
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST_N) begin
            if (r_state == ST_LOAD && in_valid) begin
                r_re[w_wr_idx] <= sm_to_tc(in_real);
                r_im[w_wr_idx] <= sm_to_tc(in_imag);
            end else if (r_state == ST_COMPUTE) begin
                r_re[w_p] <= 16'((17'(w_xp_re) + 17'(w_t_re)) >>> SCALE);
                r_im[w_p] <= 16'((17'(w_xp_im) + 17'(w_t_im)) >>> SCALE);
                r_re[w_q] <= 16'((17'(w_xp_re) - 17'(w_t_re)) >>> SCALE);
                r_im[w_q] <= 16'((17'(w_xp_im) - 17'(w_t_im)) >>> SCALE);
            end
        end
    end

    assign in_ready  = (r_state == ST_LOAD);
    assign out_valid = (r_state == ST_UNLOAD);
    assign busy      = (r_state != ST_LOAD);
    assign out_index = out_valid ? r_cnt : 3'd0;
    assign out_last  = out_valid && (r_cnt == 3'd7);
    assign out_real  = out_valid ? tc_to_sm(r_re[r_cnt]) : 16'h0000;
    assign out_imag  = out_valid ? tc_to_sm(r_im[r_cnt]) : 16'h0000;
endmodule

// File: tb/tb_eight_point_ifft_serial.sv
// tb/tb_eight_point_ifft_serial.sv - directed bench with an in-bench textbook IFFT model
module tb_eight_point_ifft_serial;
    localparam int SC = 1;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_real;
    logic [15:0] in_imag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_real;
    logic [15:0] out_imag;
    logic [2:0]  out_index;
    logic        out_last;
    logic        busy;

    eight_point_ifft_serial #(.SCALE(SC)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_real(in_real), .in_imag(in_imag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_real(out_real), .out_imag(out_imag),
        .out_index(out_index), .out_last(out_last), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        logic [2:0]  idx;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] f_re[8];
    logic [15:0] f_im[8];
    logic [15:0] m_re[8];
    logic [15:0] m_im[8];
    int          n_vec = 0;
    int          n_err = 0;
    bit          chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int wrapn(input int v, input int n);
        int u;
        u = v & ((1 << n) - 1);
        return (u >= (1 << (n - 1))) ? u - (1 << n) : u;
    endfunction

    function automatic int sm2int(input logic [15:0] v);
        int m;
        m = int'(v[14:0]);
        return v[15] ? -m : m;
    endfunction

    function automatic logic [15:0] int2sm(input int v);
        if (v == -32768) return 16'hFFFF;
        if (v < 0) return {1'b1, 15'(-v)};
        return 16'(v);
    endfunction

    function automatic int cmul(input int v);
        longint p;
        p = longint'(wrapn(v, 17)) * 64'sd23170;
        return wrapn(int'(p >>> 15), 16);
    endfunction

    // Textbook in-place decimation-in-time IFFT with W = exp(+j*2*pi*k/8)
    task automatic run_model();
        int xr[8];
        int xi[8];
        int a, b, tr, ti, p, q, k, half, nr, ni;
        for (int m = 0; m < 8; m++) begin
            int r;
            r = ((m & 1) << 2) | (m & 2) | ((m >> 2) & 1);
            xr[r] = sm2int(f_re[m]);
            xi[r] = sm2int(f_im[m]);
        end
        for (int s = 0; s < 3; s++) begin
            half = 1 << s;
            for (int g = 0; g < 8; g += 2 * half) begin
                for (int j = 0; j < half; j++) begin
                    p = g + j;
                    q = p + half;
                    k = j * (4 >> s);
                    a = xr[q];
                    b = xi[q];
                    case (k)
                        1: begin tr = cmul(a - b); ti = cmul(a + b); end
                        2: begin tr = wrapn(-b, 16); ti = a; end
                        3: begin tr = cmul(-a - b); ti = cmul(a - b); end
                        default: begin tr = a; ti = b; end
                    endcase
                    nr = wrapn((xr[p] + tr) >>> SC, 16);
                    ni = wrapn((xi[p] + ti) >>> SC, 16);
                    xr[q] = wrapn((xr[p] - tr) >>> SC, 16);
                    xi[q] = wrapn((xi[p] - ti) >>> SC, 16);
                    xr[p] = nr;
                    xi[p] = ni;
                end
            end
        end
        for (int n = 0; n < 8; n++) begin
            m_re[n] = int2sm(xr[n]);
            m_im[n] = int2sm(xi[n]);
        end
    endtask

    task automatic clear_frame();
        for (int m = 0; m < 8; m++) begin
            f_re[m] = 16'h0000;
            f_im[m] = 16'h0000;
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    check("out_real", out_real, exp_q[0].re);
                    check("out_imag", out_imag, exp_q[0].im);
                    check("out_index", out_index, exp_q[0].idx);
                    check("out_last", out_last, exp_q[0].idx == 3'd7);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end else begin
                check("idle_real", out_real, 16'h0000);
                check("idle_imag", out_imag, 16'h0000);
                check("idle_last", out_last, 1'b0);
            end
        end
    end

    task automatic send_frame(input bit push);
        exp_t e;
        int   first;
        if (push) begin
            run_model();
            for (int n = 0; n < 8; n++) begin
                e.re  = m_re[n];
                e.im  = m_im[n];
                e.idx = 3'(n);
                exp_q.push_back(e);
            end
        end
        for (int m = 0; m < 8; m++) begin
            in_valid = 1'b1;
            in_real  = f_re[m];
            in_imag  = f_im[m];
            for (int w = 0; w < 200 && !in_ready; w++) begin
                @(posedge CLK); #1;
            end
            if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
            @(posedge CLK); #1;
        end
        // junk held valid through COMPUTE must not be consumed
        in_real = 16'h7FFF;
        in_imag = 16'h1234;
        if (!push) begin
            in_valid = 1'b0;
            return;
        end
        first = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge CLK);
            if (n == 1) begin
                check("busy_in_compute", busy, 1'b1);
                check("in_ready_in_compute", in_ready, 1'b0);
            end
            if (out_valid) begin
                first = n;
                break;
            end
        end
        check("latency", first, 32'd13);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int w = 0; w < 300; w++) begin
            if (out_valid && out_last && out_ready) begin
                seen = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        check("last_seen", seen, 1'b1);
        check("in_ready_before_last", in_ready, 1'b0);
        @(posedge CLK); #1;
        check("in_ready_after_last", in_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        RST_N     = 1'b0;
        in_valid  = 1'b0;
        in_real   = 16'h0000;
        in_imag   = 16'h0000;
        out_ready = 1'b1;

        // Pin the model itself against hand-computed values
        clear_frame(); f_re[1] = 16'h0400; run_model();
        check("model_tone_n1_re", m_re[1], 16'h005A);
        check("model_tone_n3_re", m_re[3], 16'h805B);
        check("model_tone_n5_im", m_im[5], 16'h805B);
        check("model_tone_n6_im", m_im[6], 16'h8080);
        check("model_tone_n7_im", m_im[7], 16'h805B);
        clear_frame(); f_re[0] = 16'h0400; run_model();
        check("model_impulse_n4", m_re[4], 16'h0080);
        clear_frame(); f_re[0] = 16'h8400; run_model();
        check("model_neg_n0", m_re[0], 16'h8080);

        repeat (3) begin @(posedge CLK); #1; end
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_real", out_real, 16'h0000);
        check("rst_out_imag", out_imag, 16'h0000);
        check("rst_out_index", out_index, 3'd0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        RST_N  = 1'b1;
        chk_en = 1'b1;

        clear_frame(); f_re[0] = 16'h0400;
        send_frame(1'b1); wait_done();

        clear_frame();
        for (int m = 0; m < 8; m++) begin
            f_re[m] = 16'h0320;
            f_im[m] = (m == 0) ? 16'h0000 : 16'h8000;
        end
        send_frame(1'b1); wait_done();

        clear_frame(); f_re[0] = 16'h8400;
        send_frame(1'b1); wait_done();

        // Tone with backpressure at out_index 2
        clear_frame(); f_re[1] = 16'h0400;
        send_frame(1'b1);
        for (int w = 0; w < 50; w++) begin
            @(posedge CLK); #1;
            if (out_valid && out_index == 3'd2) break;
        end
        check("bp_reach_idx2", out_index, 3'd2);
        out_ready = 1'b0;
        repeat (3) begin
            @(posedge CLK); #1;
            check("bp_hold_idx", out_index, 3'd2);
            check("bp_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        wait_done();

        // Back-to-back frames with mixed values
        f_re = '{16'h1234, 16'h8567, 16'h0ABC, 16'h7FFF, 16'h8001, 16'h0100, 16'hFFFF, 16'h0000};
        f_im = '{16'h0F00, 16'h0001, 16'h8ABC, 16'h8000, 16'h7FFF, 16'h9999, 16'h0042, 16'h8100};
        send_frame(1'b1); wait_done();
        clear_frame(); f_re[3] = 16'h0800; f_im[5] = 16'h8600; f_im[2] = 16'h0300;
        send_frame(1'b1); wait_done();

        // Reset during COMPUTE cycle 5 discards the frame
        clear_frame(); f_re[2] = 16'h0555;
        send_frame(1'b0);
        repeat (4) begin @(posedge CLK); #1; end
        RST_N = 1'b0;
        @(posedge CLK); #1;
        RST_N = 1'b1;
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);

        clear_frame(); f_re[0] = 16'h0400;
        send_frame(1'b1); wait_done();

        repeat (3) @(posedge CLK);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
